zero_compress_nch: RTL and testbench
====================================

Name: zero_compress_nch

Overview:
- Parametrised N-channel zero-suppression serializer.
- Sits between the trigger FIFO (one event per entry: NCH TDC words plus one timestamp word) and the output FIFO.
- Emits only channels whose hit bit is set, in ascending channel order, optionally followed by the event timestamp.
- Inserts missed-event words through a req/ack handshake, applies output backpressure, and keeps event/word counters.

Parameters:
- NCH, 4, number of TDC channels (1..16).
- DW, 32, word width of each channel, timestamp and output word.
- HIT_BIT, 0, bit position of the hit flag inside each channel word.
- EMIT_TS, 1, 1 = append the timestamp word after each event's hits.
- DROP_EMPTY, 0, 1 = an event with zero hits produces no output at all (the timestamp is also dropped).
- CHW, $clog2(NCH) (minimum 1), local width of the channel index.

Ports:
- clk  in  1  clock (160 MHz).
- reset  in  1  synchronous, active-high.
- din  in  (NCH+1)*DW  FWFT trigger FIFO data; channel c = din[c*DW +: DW], timestamp = din[NCH*DW +: DW].
- in_empty  in  1  trigger FIFO empty.
- in_rd_en  out  1  pop trigger FIFO (combinational).
- miss_req  in  1  level request to write one missed-event word.
- miss_data  in  DW  missed-event word.
- miss_ack  out  1  one-cycle registered pulse: miss_data was written.
- out_afull  in  1  output FIFO almost full.
- dout  out  DW  output word.
- dout_type  out  2  0 = TDC, 1 = timestamp, 2 = missed event, 3 = reserved (never emitted).
- dout_ch  out  CHW  channel index for TDC words, else 0.
- out_wr_en  out  1  output FIFO write strobe.
- evt_cnt  out  16  count of events popped; wraps.
- word_cnt  out  32  count of words written; wraps.

Behaviour:
- Reset values: all outputs 0, state IDLE, event register 0, pending-mask 0.
- ready = !out_afull.
- A slot is a cycle with ready = 1. At most one word is written per slot.
- dout, dout_type, dout_ch and out_wr_en are registered: a word decided in cycle n appears with out_wr_en = 1 in cycle n+1.
- Priority: when a slot exists and miss_req = 1, the missed word wins that slot in any state.
  - Event emission stalls for that cycle; no pop occurs.
  - miss_ack pulses together with out_wr_en.
  - The requester must drop or re-evaluate miss_req after seeing the ack. If miss_req is still high the cycle after the ack, it is treated as a new request.
- States:
  - IDLE: if slot, !miss_req and !in_empty, then in_rd_en = 1. din is captured into the event register, pending-mask = hit bits, evt_cnt++, go to EMIT.
  - EMIT: each slot without miss_req emits one word.
    - If pending-mask != 0: emit the lowest set channel (type 0, dout_ch = index) and clear its mask bit.
    - Else if EMIT_TS and !(DROP_EMPTY and the event had no hits): emit the timestamp (type 1).
  - Event completion occurs in the cycle its last word is emitted, or immediately in the first EMIT cycle if nothing is to be emitted.
    - If !in_empty, the next event is popped in that same cycle (in_rd_en = 1, back-to-back, stay in EMIT).
    - Otherwise go to IDLE.
- Throughput: one word per cycle sustained. An event with k hits plus a timestamp occupies k+1 slots.
- Zero-hit event:
  - EMIT_TS = 1, DROP_EMPTY = 0: timestamp only.
  - DROP_EMPTY = 1: nothing emitted; still counted in evt_cnt; completes in 1 cycle.
  - EMIT_TS = 0, DROP_EMPTY = 0: nothing emitted; completes in 1 cycle.
- Backpressure: while out_afull = 1, there is no write, no pop and no state change. The mask and event register hold.
- in_rd_en is never asserted when in_empty = 1, nor when miss_req takes the slot.
- Hit bits are taken only from the captured register, never from live din after the pop.
- Counters wrap silently (0xFFFF -> 0). word_cnt increments on every out_wr_en.
- Reset mid-event: the partially emitted event is discarded, the FIFO is not re-popped, and out_wr_en is 0 in the cycle after reset.

Test Plan:
- NCH=4, one event with hits on ch1 and ch3, ts=0xABCD0000, afull=0 -> words (0,ch1), (0,ch3), (1,ts) on 3 consecutive cycles; in_rd_en high once; evt_cnt=1, word_cnt=3.
- Three events back-to-back with 4, 0 and 2 hits, EMIT_TS=1 -> 5+1+3 = 9 words with no idle cycle between events; the second event emits its ts only.
- DROP_EMPTY=1, zero-hit event followed by a 1-hit event -> the first produces no words; output is (0,chX), (1,ts); evt_cnt=2.
- miss_req asserted in the middle of a 4-hit event -> the missed word (type 2) is inserted between TDC words; miss_ack is a single pulse; the total TDC order is unchanged.
- out_afull toggled 1/0 every 2 cycles during a 4-hit event -> no word lost or duplicated; no writes during afull; in_rd_en only when afull=0.
- reset asserted after 2 of 4 hits have been emitted -> all outputs 0 next cycle; after release with in_empty=0, a new pop occurs and the remaining hits of the old event are not emitted. NCH=8 variant: dout_ch reaches 7.

Source files
------------

// File: rtl/zero_compress_nch.sv
`default_nettype none
// ============================================================================
//  Module   : zero_compress_nch
//  Purpose  : N-channel zero-suppression serializer. Pops one event (NCH TDC
//             words + one timestamp word) from an FWFT trigger FIFO and writes
//             only the channels whose hit bit is set, lowest channel first,
//             optionally followed by the timestamp. Missed-event words from a
//             req/ack side port take priority over event words. One output
//             word per cycle while the output FIFO is not almost full.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock
//    reset      in   synchronous, active-high reset
//    din        in   (NCH+1)*DW  event: ch c at [c*DW +: DW], ts at [NCH*DW +: DW]
//    in_empty   in   trigger FIFO empty
//    in_rd_en   out  trigger FIFO pop (combinational)
//    miss_req   in   level request to write miss_data
//    miss_data  in   DW   missed-event word
//    miss_ack   out  registered pulse, coincident with the miss word write
//    out_afull  in   output FIFO almost full (no slot while high)
//    dout       out  DW   output word
//    dout_type  out  2    0 TDC, 1 timestamp, 2 missed event
//    dout_ch    out  CHW  channel of TDC words, 0 otherwise
//    out_wr_en  out  output FIFO write strobe
//    evt_cnt    out  16   events popped (wraps)
//    word_cnt   out  32   words written (wraps)
// ============================================================================
module zero_compress_nch #(
   parameter int NCH        = 4,
   parameter int DW         = 32,
   parameter int HIT_BIT    = 0,
   parameter bit EMIT_TS    = 1'b1,
   parameter bit DROP_EMPTY = 1'b0,
   localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [(NCH+1)*DW-1:0] din,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   input  logic                  miss_req,
   input  logic [DW-1:0]         miss_data,
   output logic                  miss_ack,
   input  logic                  out_afull,
   output logic [DW-1:0]         dout,
   output logic [1:0]            dout_type,
   output logic [CHW-1:0]        dout_ch,
   output logic                  out_wr_en,
   output logic [15:0]           evt_cnt,
   output logic [31:0]           word_cnt
);

   localparam logic [1:0] TYPE_TDC  = 2'd0;
   localparam logic [1:0] TYPE_TS   = 2'd1;
   localparam logic [1:0] TYPE_MISS = 2'd2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [(NCH+1)*DW-1:0]   evt_q, evt_d;
   logic [NCH-1:0]          mask_q, mask_d;
   // Timestamp still owed for the current event; decided once at capture so
   // the DROP_EMPTY rule never has to look back at the original hit pattern.
   logic                    ts_pend_q, ts_pend_d;
   logic [DW-1:0]           dout_q, dout_d;
   logic [1:0]              dout_type_q, dout_type_d;
   logic [CHW-1:0]          dout_ch_q, dout_ch_d;
   logic                    out_wr_en_q, out_wr_en_d;
   logic                    miss_ack_q, miss_ack_d;
   logic [15:0]             evt_cnt_q, evt_cnt_d;
   logic [31:0]             word_cnt_q, word_cnt_d;

   logic [NCH-1:0]          din_hits;
   logic [CHW-1:0]          low_idx;
   logic [NCH-1:0]          low_onehot;
   logic [DW-1:0]           low_word;
   logic [NCH-1:0]          mask_after;
   logic                    ready;
   logic                    pop;
   logic                    done;

   // Hit flags of the event currently at the FIFO head (used only at capture).
   genvar gc;
   generate
      for (gc = 0; gc < NCH; gc++) begin : g_hits
         assign din_hits[gc] = din[gc*DW + HIT_BIT];
      end
   endgenerate

   // Lowest pending channel. Scanning downward lets the last match win.
   always_comb begin
      low_idx    = '0;
      low_onehot = '0;
      low_word   = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (mask_q[c]) begin
            low_idx         = CHW'(c);
            low_onehot      = '0;
            low_onehot[c]   = 1'b1;
            low_word        = evt_q[c*DW +: DW];
         end
      end
   end

   assign mask_after = mask_q & ~low_onehot;
   assign ready      = !out_afull;

   always_comb begin
      state_d     = state_q;
      evt_d       = evt_q;
      mask_d      = mask_q;
      ts_pend_d   = ts_pend_q;
      dout_d      = '0;
      dout_type_d = TYPE_TDC;
      dout_ch_d   = '0;
      out_wr_en_d = 1'b0;
      miss_ack_d  = 1'b0;
      evt_cnt_d   = evt_cnt_q;
      pop         = 1'b0;
      done        = 1'b0;

      if (ready && miss_req) begin
         // Missed word owns this slot; event progress is frozen.
         dout_d      = miss_data;
         dout_type_d = TYPE_MISS;
         out_wr_en_d = 1'b1;
         miss_ack_d  = 1'b1;
      end else if (ready) begin
         case (state_q)
            IDLE: begin
               pop = !in_empty;
            end
            EMIT: begin
               if (mask_q != '0) begin
                  dout_d      = low_word;
                  dout_type_d = TYPE_TDC;
                  dout_ch_d   = low_idx;
                  out_wr_en_d = 1'b1;
                  mask_d      = mask_after;
                  done        = (mask_after == '0) && !ts_pend_q;
               end else if (ts_pend_q) begin
                  dout_d      = evt_q[NCH*DW +: DW];
                  dout_type_d = TYPE_TS;
                  out_wr_en_d = 1'b1;
                  ts_pend_d   = 1'b0;
                  done        = 1'b1;
               end else begin
                  // Event with nothing to emit completes without a write.
                  done = 1'b1;
               end
               if (done) begin
                  state_d = IDLE;
                  pop     = !in_empty;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (pop) begin
            evt_d     = din;
            mask_d    = din_hits;
            ts_pend_d = EMIT_TS && !(DROP_EMPTY && (din_hits == '0));
            evt_cnt_d = evt_cnt_q + 16'd1;
            state_d   = EMIT;
         end
      end

      word_cnt_d = word_cnt_q + {31'd0, out_wr_en_d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         evt_q       <= '0;
         mask_q      <= '0;
         ts_pend_q   <= 1'b0;
         dout_q      <= '0;
         dout_type_q <= TYPE_TDC;
         dout_ch_q   <= '0;
         out_wr_en_q <= 1'b0;
         miss_ack_q  <= 1'b0;
         evt_cnt_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         evt_q       <= evt_d;
         mask_q      <= mask_d;
         ts_pend_q   <= ts_pend_d;
         dout_q      <= dout_d;
         dout_type_q <= dout_type_d;
         dout_ch_q   <= dout_ch_d;
         out_wr_en_q <= out_wr_en_d;
         miss_ack_q  <= miss_ack_d;
         evt_cnt_q   <= evt_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   // Pop is suppressed during reset so an aborted event's successor stays
   // in the FIFO until the block is running again.
   assign in_rd_en  = pop && !reset;
   assign miss_ack  = miss_ack_q;
   assign dout      = dout_q;
   assign dout_type = dout_type_q;
   assign dout_ch   = dout_ch_q;
   assign out_wr_en = out_wr_en_q;
   assign evt_cnt   = evt_cnt_q;
   assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_zero_compress_nch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zero_compress_nch
//  Purpose  : Self-checking bench for zero_compress_nch. Instance A uses the
//             default configuration (NCH=4, EMIT_TS=1, DROP_EMPTY=0) fed by
//             a bench-side FIFO; instance B uses NCH=8 with DROP_EMPTY=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zero_compress_nch;
   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int EW  = (NCH+1)*DW;
   localparam int EWB = 9*DW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- instance A ----------------
   logic [EW-1:0] din;
   logic          in_empty, in_rd_en, miss_req, miss_ack, out_afull, out_wr_en;
   logic [DW-1:0] miss_data, dout;
   logic [1:0]    dout_type;
   logic [1:0]    dout_ch;
   logic [15:0]   evt_cnt;
   logic [31:0]   word_cnt;

   zero_compress_nch #(.NCH(NCH), .DW(DW), .HIT_BIT(0), .EMIT_TS(1'b1), .DROP_EMPTY(1'b0)) dut_a (
      .clk(clk), .reset(reset), .din(din), .in_empty(in_empty), .in_rd_en(in_rd_en),
      .miss_req(miss_req), .miss_data(miss_data), .miss_ack(miss_ack), .out_afull(out_afull),
      .dout(dout), .dout_type(dout_type), .dout_ch(dout_ch), .out_wr_en(out_wr_en),
      .evt_cnt(evt_cnt), .word_cnt(word_cnt));

   // ---------------- instance B ----------------
   logic [EWB-1:0] din_b;
   logic           in_empty_b, in_rd_en_b, miss_ack_b, out_wr_en_b;
   logic [DW-1:0]  dout_b;
   logic [1:0]     dout_type_b;
   logic [2:0]     dout_ch_b;
   logic [15:0]    evt_cnt_b;
   logic [31:0]    word_cnt_b;

   zero_compress_nch #(.NCH(8), .DW(DW), .HIT_BIT(0), .EMIT_TS(1'b1), .DROP_EMPTY(1'b1)) dut_b (
      .clk(clk), .reset(reset), .din(din_b), .in_empty(in_empty_b), .in_rd_en(in_rd_en_b),
      .miss_req(1'b0), .miss_data('0), .miss_ack(miss_ack_b), .out_afull(1'b0),
      .dout(dout_b), .dout_type(dout_type_b), .dout_ch(dout_ch_b), .out_wr_en(out_wr_en_b),
      .evt_cnt(evt_cnt_b), .word_cnt(word_cnt_b));

   typedef struct packed {
      logic [1:0]  t;
      logic [3:0]  ch;
      logic [31:0] d;
   } word_t;

   typedef struct {
      logic [3:0] hits;
      int         exp_words;
      logic [1:0] exp_first_t;
      logic [3:0] exp_first_ch;
      logic [1:0] exp_last_t;
      logic [3:0] exp_last_ch;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int pops  = 0;
   int acks  = 0;

   logic [EW-1:0] fifo_a[$];
   word_t         obs[$];
   word_t         exp_q[$];
   logic [DW-1:0] miss_exp[$];
   int            wr_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive_fifo();
      in_empty = (fifo_a.size() == 0);
      din      = (fifo_a.size() != 0) ? fifo_a[0] : '0;
   endtask

   function automatic logic [EW-1:0] make_event(input logic [3:0] hits, input logic [31:0] ts);
      logic [EW-1:0] e;
      logic [31:0]   r;
      for (int c = 0; c < NCH; c++) begin
         r = $urandom();
         e[c*DW +: DW] = {r[31:1], hits[c]};
      end
      e[NCH*DW +: DW] = ts;
      return e;
   endfunction

   // Reference: hit channels ascending, then the timestamp (always, since
   // DROP_EMPTY=0 and EMIT_TS=1 for instance A).
   function automatic void model_event(input logic [EW-1:0] e);
      for (int c = 0; c < NCH; c++)
         if (e[c*DW]) exp_q.push_back('{t: 2'd0, ch: 4'(c), d: e[c*DW +: DW]});
      exp_q.push_back('{t: 2'd1, ch: 4'd0, d: e[NCH*DW +: DW]});
   endfunction

   task automatic push_event(input logic [3:0] hits, input logic [31:0] ts);
      logic [EW-1:0] e;
      e = make_event(hits, ts);
      fifo_a.push_back(e);
      model_event(e);
      drive_fifo();
   endtask

   task automatic raise_miss();
      miss_data = $urandom();
      miss_req  = 1'b1;
      miss_exp.push_back(miss_data);
   endtask

   // One clock cycle on instance A with protocol checks.
   task automatic tick();
      logic rd, afull_prev;
      #2;
      rd         = in_rd_en;
      afull_prev = out_afull;
      chk("rd_while_empty", rd & in_empty, 1'b0);
      chk("rd_while_afull", rd & out_afull, 1'b0);
      chk("rd_while_miss",  rd & miss_req, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
      if (rd) begin
         void'(fifo_a.pop_front());
         pops++;
      end
      if (out_wr_en) begin
         obs.push_back('{t: dout_type, ch: {2'b00, dout_ch}, d: dout});
         wr_cyc.push_back(cyc);
         chk("type_reserved", dout_type == 2'd3, 1'b0);
      end
      chk("write_after_afull", out_wr_en & afull_prev, 1'b0);
      chk("ack_vs_miss_write", miss_ack, out_wr_en && dout_type == 2'd2);
      if (miss_ack) begin
         acks++;
         miss_req = 1'b0;
      end
      drive_fifo();
   endtask

   task automatic clear_q();
      obs.delete(); exp_q.delete(); miss_exp.delete(); wr_cyc.delete();
      pops = 0; acks = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; miss_req = 1'b0; out_afull = 1'b0; miss_data = '0;
      fifo_a.delete();
      drive_fifo();
      tick(); tick();
      reset = 1'b0;
      clear_q();
   endtask

   task automatic drain(input string tag);
      int idle = 0;
      int n    = 0;
      out_afull = 1'b0;
      while ((fifo_a.size() != 0 || miss_req || idle < 4) && n < 2000) begin
         tick();
         n++;
         idle = out_wr_en ? 0 : idle + 1;
      end
      chk({tag, "_drain_timeout"}, n >= 2000, 1'b0);
   endtask

   task automatic compare_streams(input string tag);
      word_t ev[$];
      word_t ms[$];
      foreach (obs[i]) begin
         if (obs[i].t == 2'd2) ms.push_back(obs[i]);
         else ev.push_back(obs[i]);
      end
      chk({tag, "_nwords"}, ev.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ev.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), ev[i], exp_q[i]);
      chk({tag, "_nmiss"}, ms.size(), miss_exp.size());
      for (int i = 0; i < miss_exp.size() && i < ms.size(); i++)
         chk($sformatf("%s_miss%0d", tag, i), ms[i].d, miss_exp[i]);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int   d;
      logic rdb;
      int   pops_b;
      int   pop_cyc_b[$];
      word_t obs_b[$];
      logic [EWB-1:0] ev0_b, ev1_b;

      reset = 1'b1; in_empty = 1'b1; din = '0; miss_req = 1'b0; miss_data = '0; out_afull = 1'b0;
      din_b = '0; in_empty_b = 1'b1;
      @(posedge clk); #1;

      // ---- reset state ----
      do_reset();
      chk("rst_wr_en", out_wr_en, 1'b0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_type", dout_type, 2'd0);
      chk("rst_ch", dout_ch, 2'd0);
      chk("rst_ack", miss_ack, 1'b0);
      chk("rst_evt_cnt", evt_cnt, 16'd0);
      chk("rst_word_cnt", word_cnt, 32'd0);
      chk("rst_b_wr_en", out_wr_en_b, 1'b0);

      // ---- table: single events ----
      vt[0] = '{4'b0000, 1, 2'd1, 4'd0, 2'd1, 4'd0};
      vt[1] = '{4'b0001, 2, 2'd0, 4'd0, 2'd1, 4'd0};
      vt[2] = '{4'b1000, 2, 2'd0, 4'd3, 2'd1, 4'd0};
      vt[3] = '{4'b1111, 5, 2'd0, 4'd0, 2'd1, 4'd0};
      vt[4] = '{4'b0110, 3, 2'd0, 4'd1, 2'd1, 4'd0};
      for (int i = 0; i < 5; i++) begin
         do_reset();
         push_event(vt[i].hits, 32'h1000_0000 + i);
         drain($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_count", i), obs.size(), vt[i].exp_words);
         if (obs.size() != 0) begin
            chk($sformatf("tbl%0d_first", i), {obs[0].t, obs[0].ch}, {vt[i].exp_first_t, vt[i].exp_first_ch});
            chk($sformatf("tbl%0d_last", i), {obs[obs.size()-1].t, obs[obs.size()-1].ch},
                {vt[i].exp_last_t, vt[i].exp_last_ch});
         end
         compare_streams($sformatf("tbl%0d", i));
      end

      // ---- ch1+ch3 event, exact timing and counters ----
      do_reset();
      push_event(4'b1010, 32'hABCD_0000);
      drain("t1");
      compare_streams("t1");
      d = (wr_cyc.size() == 3) ? 0 : -1;
      if (d == 0) d = wr_cyc[2] - wr_cyc[0];
      chk("t1_consecutive", d, 2);
      chk("t1_pops", pops, 1);
      chk("t1_evt_cnt", evt_cnt, 16'd1);
      chk("t1_word_cnt", word_cnt, 32'd3);

      // ---- 4, 0, 2 hits back-to-back ----
      do_reset();
      push_event(4'b1111, 32'h2000_0001);
      push_event(4'b0000, 32'h2000_0002);
      push_event(4'b0101, 32'h2000_0003);
      drain("b2b");
      compare_streams("b2b");
      d = (wr_cyc.size() == 9) ? 0 : -1;
      if (d == 0) d = wr_cyc[8] - wr_cyc[0];
      chk("b2b_no_gap", d, 8);
      chk("b2b_evt_cnt", evt_cnt, 16'd3);

      // ---- missed word in the middle of a 4-hit event ----
      do_reset();
      push_event(4'b1111, 32'h3000_0000);
      tick(); tick(); tick();
      raise_miss();
      drain("miss");
      compare_streams("miss");
      chk("miss_acks", acks, 1);
      chk("miss_position", (obs.size() > 2) ? obs[2].t : 2'd3, 2'd2);

      // ---- afull toggling every 2 cycles ----
      do_reset();
      push_event(4'b1111, 32'h4000_0000);
      for (int i = 0; i < 24; i++) begin
         out_afull = ((i / 2) % 2) == 1;
         tick();
      end
      drain("afull");
      compare_streams("afull");

      // ---- reset after 2 of 4 hits ----
      do_reset();
      push_event(4'b1111, 32'h5000_0000);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      push_event(4'b0100, 32'h5000_0001);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_wr_en", out_wr_en, 1'b0);
      chk("mid_rst_outs", {dout, dout_type, dout_ch, miss_ack}, 37'd0);
      chk("mid_rst_cnts", {evt_cnt, word_cnt}, 48'd0);
      reset = 1'b0;
      drain("mid_rst");
      compare_streams("mid_rst");
      chk("mid_rst_pops", pops, 2);
      chk("mid_rst_evt_cnt", evt_cnt, 16'd1);

      // ---- randomized traffic against the model ----
      do_reset();
      d = 0;
      for (int i = 0; i < 600; i++) begin
         if (d < 80 && $urandom_range(0, 2) == 0) begin
            push_event(4'($urandom_range(0, 15)), $urandom());
            d++;
         end
         out_afull = ($urandom_range(0, 3) == 0);
         if (!miss_req && $urandom_range(0, 9) == 0) raise_miss();
         tick();
      end
      drain("rnd");
      compare_streams("rnd");
      chk("rnd_evt_cnt", evt_cnt, 16'(d));
      chk("rnd_word_cnt", word_cnt, 32'(obs.size()));
      chk("rnd_acks", acks, miss_exp.size());

      // ---- instance B: DROP_EMPTY zero-hit event then ch7 hit ----
      for (int c = 0; c < 8; c++) begin
         ev0_b[c*DW +: DW] = 32'h1234_5678;
         ev1_b[c*DW +: DW] = (c == 7) ? 32'hC0FF_EE01 : 32'h5A5A_5A5A;
      end
      ev0_b[8*DW +: DW] = 32'h1111_1111;
      ev1_b[8*DW +: DW] = 32'h2222_0007;
      din_b = ev0_b; in_empty_b = 1'b0; pops_b = 0;
      for (int i = 0; i < 12; i++) begin
         #2;
         rdb = in_rd_en_b;
         chk("b_rd_while_empty", rdb & in_empty_b, 1'b0);
         @(posedge clk); #1;
         cyc++;
         if (rdb) begin
            pops_b++;
            pop_cyc_b.push_back(cyc);
            if (pops_b == 1) din_b = ev1_b;
            else begin in_empty_b = 1'b1; din_b = '0; end
         end
         if (out_wr_en_b) obs_b.push_back('{t: dout_type_b, ch: {1'b0, dout_ch_b}, d: dout_b});
      end
      chk("b_pops", pops_b, 2);
      d = (pop_cyc_b.size() == 2) ? 0 : -1;
      if (d == 0) d = pop_cyc_b[1] - pop_cyc_b[0];
      chk("b_empty_one_cycle", d, 1);
      chk("b_nwords", obs_b.size(), 2);
      if (obs_b.size() == 2) begin
         chk("b_word0", obs_b[0], {2'd0, 4'd7, 32'hC0FF_EE01});
         chk("b_word1", obs_b[1], {2'd1, 4'd0, 32'h2222_0007});
      end
      chk("b_evt_cnt", evt_cnt_b, 16'd2);
      chk("b_word_cnt", word_cnt_b, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
